uarttx_arbiter: RTL
===================

# uarttx_arbiter

Round-robin, packet-locked arbiter that shares one `uarttx` transmitter among `NUM_REQ` requesters. Each requester offers bytes with a valid/ready handshake and marks the final byte of a packet with a last flag. The arbiter holds the grant for a whole packet, sequences bytes into the transmitter's `i_TX_DV`/`i_TX_Byte`, and waits for `o_TX_Done` between bytes. It enforces a programmable idle gap between packets and sits directly in front of `uarttx`.

## Interface

**Parameters**
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `GAP_CLKS`, default 217: minimum idle clocks between packets; 0 disables the gap.

**Ports**
- `i_Clock`, input, 1: system clock; all logic on the rising edge.
- `i_Rst_n`, input, 1: reset, asynchronous, active-low.
- `i_Req_Valid`, input, `NUM_REQ`: requester k has a byte available.
- `i_Req_Byte`, input, `8*NUM_REQ`: byte for requester k at `[8k+7:8k]`; held stable while valid and not yet accepted.
- `i_Req_Last`, input, `NUM_REQ`: the byte offered by requester k is the last byte of its packet.
- `o_Req_Ready`, output, `NUM_REQ`: one-cycle pulse; the byte for requester k is accepted this cycle.
- `o_Grant`, output, `NUM_REQ`: one-hot current owner, or 0.
- `o_Busy`, output, 1: high in any state other than IDLE.
- `o_TX_DV`, output, 1: drives `uarttx.i_TX_DV`.
- `o_TX_Byte`, output, 8: drives `uarttx.i_TX_Byte`.
- `i_TX_Active`, input, 1: from `uarttx.o_TX_Active`.
- `i_TX_Done`, input, 1: from `uarttx.o_TX_Done`, a one-clock pulse at the end of the stop bit.

## Operation

- All outputs are registered.
- States are IDLE, LOAD, WAIT_DONE and GAP.
- **IDLE**
  - Leaves IDLE only when `i_Req_Valid != 0` and `i_TX_Active == 0`.
  - Selects the first valid requester searching upward from `last_grant+1`, modulo `NUM_REQ`.
  - Registers the selection in `o_Grant` and moves to LOAD.
- **LOAD**
  - When the granted requester's valid bit is high, the arbiter does the following for exactly one cycle:
    - pulses `o_TX_DV` with `o_TX_Byte` set to that requester's byte;
    - pulses that requester's bit of `o_Req_Ready`;
    - captures its `i_Req_Last` into `last_flag`.
  - It then moves to WAIT_DONE.
  - If the granted valid bit is low, the arbiter stays in LOAD indefinitely and keeps the grant. The packet lock is not broken by a stalled requester.
- **WAIT_DONE**
  - Waits for `i_TX_Done`.
  - If `last_flag` is 0, returns to LOAD.
  - If `last_flag` is 1:
    - clears `o_Grant`;
    - sets `last_grant` to the owner;
    - goes to GAP, or to IDLE when `GAP_CLKS == 0`.
- **GAP**
  - Counts `GAP_CLKS` clocks with a counter of width `$clog2(GAP_CLKS+1)`, then goes to IDLE.
- `o_TX_Byte` holds its last value when `o_TX_DV` is low. It is 0 after reset.
- Only the granted requester can ever see `o_Req_Ready`. Valid bits of non-granted requesters are ignored.
- `i_TX_Done` is ignored outside WAIT_DONE.

## Timing

- **Reset values:**
  - `o_Req_Ready`, `o_Grant`, `o_Busy`, `o_TX_DV` and `o_TX_Byte` are all 0.
  - State is IDLE and the gap counter is 0.
  - `last_grant = NUM_REQ-1`, so requester 0 has first priority.
- **Grant latency:** a valid sampled in IDLE at edge N gives `o_Grant` and `o_Busy` high after edge N. `o_TX_DV` and `o_Req_Ready` are high after edge N+1 for one cycle.
- **Inter-byte spacing:** `i_TX_Done` sampled at edge M gives LOAD after M. The next `o_TX_DV` appears after M+1 at the earliest.
- **Inter-packet spacing:** after the last byte's `i_TX_Done`, the earliest next `o_Grant` is `GAP_CLKS+1` clocks later.
- **Simultaneous events:**
  - At release, the releasing requester's new valid competes under round-robin from `last_grant+1`. It wins only if no other requester is valid.
- **Reset during operation:**
  - All outputs clear immediately, asynchronously.
  - `uarttx` has no reset and may complete its frame. After reset deasserts, the arbiter issues no `o_TX_DV` while `i_TX_Active` is high.
- **Single-requester packets:** a packet of one byte (last=1) uses exactly one LOAD/WAIT_DONE pass.

## Test plan

- **Single byte.** Set `GAP_CLKS=4`; requester 0 offers 0xAA with last=1.
  - Required: `o_Grant=0001`, one `o_TX_DV` pulse with 0xAA, and one `o_Req_Ready[0]` pulse in the same cycle.
  - After `i_TX_Done`, the grant drops and `o_Busy` stays high 4 clocks then goes low.
- **Packet lock.** Requester 1 sends 0x11, 0x22, 0x33 with last on 0x33, while requester 2 is valid throughout.
  - Required: three DV pulses in order, each after the previous `i_TX_Done`.
  - `o_Grant[2]` rises only after the gap that follows 0x33.
- **Round robin.** `NUM_REQ=4`; all requesters are continuously valid with single-byte packets 0x40+k.
  - Required: grant order 0, 1, 2, 3, 0 and bytes 0x40, 0x41, 0x42, 0x43, 0x40.
- **Release collision.** Requester 0 re-asserts valid in the release cycle while requester 3 is waiting.
  - Required: requester 3 is granted next, then requester 0.
- **Reset during WAIT_DONE.** Assert `i_Rst_n=0` with `i_TX_Active=1`.
  - Required: all outputs are 0 within the same cycle.
  - After release, with requester 0 valid, `o_TX_DV` stays low until `i_TX_Active` falls and then follows the grant latency.
- **Stall and no-gap.** Set `GAP_CLKS=0`; requester 2 drops valid after its first byte of a 2-byte packet for 50 clocks.
  - Required: the grant holds in LOAD with no DV; the second byte is sent after valid returns.
  - IDLE is entered the clock after the final `i_TX_Done`.

Source files
------------

// File: rtl/uarttx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uarttx transmitter among NUM_REQ requesters.
// The grant is held for a whole packet, and an idle gap of GAP_CLKS clocks follows each packet.
//
// state        | meaning
// ST_IDLE      | no owner; grant the next valid requester once the transmitter is idle
// ST_LOAD      | owner holds the grant; hand its next byte to uarttx when valid
// ST_WAIT_DONE | byte in flight; wait for the uarttx done pulse
// ST_GAP       | packet finished; count out the inter-packet idle gap
module uarttx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int GAP_CLKS = 217
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [NUM_REQ-1:0]   i_Req_Valid,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int GAP_W = (GAP_CLKS > 0) ? $clog2(GAP_CLKS + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_GAP       = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   owner;
  logic               last_flag;
  logic [GAP_W-1:0]   gap_cnt;

  logic [IDX_W-1:0]   next_owner;
  logic [NUM_REQ-1:0] next_onehot;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_byte;
  int                 cand;

  // Walk downward so the last hit is the first valid requester above last_grant.
  always_comb begin
    next_owner = last_grant;
    cand       = 0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = (int'(last_grant) + i) % NUM_REQ;
      if (i_Req_Valid[cand]) next_owner = IDX_W'(cand);
    end
    next_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << next_owner;
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_byte  = 8'h00;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        sel_valid = i_Req_Valid[k];
        sel_last  = i_Req_Last[k];
        sel_byte  = i_Req_Byte[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      owner       <= '0;
      last_flag   <= 1'b0;
      gap_cnt     <= '0;
      o_Req_Ready <= '0;
      o_Grant     <= '0;
      o_Busy      <= 1'b0;
      o_TX_DV     <= 1'b0;
      o_TX_Byte   <= 8'h00;
    end else begin
      o_TX_DV     <= 1'b0;
      o_Req_Ready <= '0;
      case (state)
        ST_IDLE: begin
          // uarttx has no reset, so a frame may still be running after our reset.
          if ((|i_Req_Valid) && !i_TX_Active) begin
            owner   <= next_owner;
            o_Grant <= next_onehot;
            o_Busy  <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (sel_valid) begin
            o_TX_DV     <= 1'b1;
            o_TX_Byte   <= sel_byte;
            o_Req_Ready <= o_Grant;
            last_flag   <= sel_last;
            state       <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (i_TX_Done) begin
            if (!last_flag) begin
              state <= ST_LOAD;
            end else begin
              o_Grant    <= '0;
              last_grant <= owner;
              if (GAP_CLKS == 0) begin
                o_Busy <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                gap_cnt <= GAP_W'(GAP_CLKS);
                state   <= ST_GAP;
              end
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            gap_cnt <= '0;
            o_Busy  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
